// File: rtl/axi_uart_pkg.sv
// -----------------------------------------------------------------------------
// axi_uart_pkg
// Shared definitions for the oversampling UART receiver and its FIFO:
//   - rx_state_e       : receiver FSM state encoding
//   - TDATA_W, *_BIT   : layout of the 11-bit output word
//   - data_bits_count  : decode of the 2-bit data_bits field to 5..8
//   - make_word        : packs status flags and data into an output word
// -----------------------------------------------------------------------------
package axi_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP1   = 3'd4,
      ST_STOP2   = 3'd5,
      ST_BRKWAIT = 3'd6
   } rx_state_e;

   localparam int TDATA_W  = 11;
   localparam int BRK_BIT  = 10;
   localparam int FERR_BIT = 9;
   localparam int PERR_BIT = 8;

   // 00=5, 01=6, 10=7, 11=8 data bits.
   function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
      return 4'd5 + {2'b00, sel};
   endfunction

   function automatic logic [TDATA_W-1:0] make_word(input logic       brk,
                                                     input logic       ferr,
                                                     input logic       perr,
                                                     input logic [7:0] data);
      logic [TDATA_W-1:0] w;
      w           = '0;
      w[BRK_BIT]  = brk;
      w[FERR_BIT] = ferr;
      w[PERR_BIT] = perr;
      w[7:0]      = data;
      return w;
   endfunction

endpackage

// File: rtl/axi_uart_rx_ovs_if.sv
// -----------------------------------------------------------------------------
// axi_uart_rx_ovs_if
// AXI-Stream style character channel out of the UART receiver.
//   o_tdata  : [10] break, [9] framing_err, [8] parity_err, [7:0] data
//   o_tvalid : a character is available
//   o_tready : consumer accepts the character this cycle
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface axi_uart_rx_ovs_if;

   logic [axi_uart_pkg::TDATA_W-1:0] o_tdata;
   logic                             o_tvalid;
   logic                             o_tready;

   modport master (output o_tdata, output o_tvalid, input o_tready);
   modport slave  (input o_tdata, input o_tvalid, output o_tready);

endinterface

// File: rtl/axi_uart_fifo.sv
// -----------------------------------------------------------------------------
// axi_uart_fifo
// First-word-fall-through FIFO of 2**SIZE entries of WIDTH bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (dropped if full and no pop this cycle)
//   wr_data    : word to push
//   rd_en      : pop the head word (ignored when empty)
//   rd_data    : head word, valid while empty=0; 0 when empty
//   empty      : no entries held
//   level      : entries held, 0..2**SIZE
//   overrun    : one-cycle pulse after a push was dropped
// -----------------------------------------------------------------------------
module axi_uart_fifo #(
   parameter int WIDTH = 11,
   parameter int SIZE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [SIZE:0]    level,
   output logic             overrun
);

   localparam int DEPTH = 2 ** SIZE;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SIZE-1:0]  wr_ptr;
   logic [SIZE-1:0]  rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty = (level == '0);
   assign full  = (level == (SIZE+1)'(DEPTH));
   assign do_rd = rd_en & ~empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign do_wr = wr_en & (~full | do_rd);

   // Forcing 0 while empty keeps the output defined before the first write.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; only pointers and
   // level carry state, so reset empties the FIFO without clearing each word.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= wr_en & full & ~do_rd;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/axi_uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// axi_uart_rx_ovs
// UART receiver with 3-point majority sampling, 5..8 data bits, optional
// parity, 1 or 2 stop bits, break detection and an FWFT output FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clkdiv        : clk cycles per bit (>= 8)
//   data_bits     : 00=5, 01=6, 10=7, 11=8 data bits
//   parity_enable : a parity bit follows the data bits
//   parity_type   : 0 = even, 1 = odd
//   stop_bits     : 0 = one stop bit, 1 = two stop bits
//   rx            : asynchronous serial line, idles high
//   m_axis        : character stream out (o_tdata/o_tvalid/o_tready)
//   fifo_level    : characters buffered
//   overrun       : pulse when a character is dropped on a full FIFO
//   rx_idle       : receiver FSM is idle
// -----------------------------------------------------------------------------
module axi_uart_rx_ovs
   import axi_uart_pkg::*;
#(
   parameter int SIZE  = 4,
   parameter int DIV_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DIV_W-1:0]         clkdiv,
   input  logic [1:0]               data_bits,
   input  logic                     parity_enable,
   input  logic                     parity_type,
   input  logic                     stop_bits,
   input  logic                     rx,
   axi_uart_rx_ovs_if.master        m_axis,
   output logic [SIZE:0]            fifo_level,
   output logic                     overrun,
   output logic                     rx_idle
);

   logic               rx_meta;
   logic               rx_sync;
   rx_state_e          state;
   logic [DIV_W-1:0]   cnt;
   logic [DIV_W-1:0]   cfg_div;
   logic [3:0]         cfg_nbits;
   logic               cfg_pen;
   logic               cfg_ptype;
   logic               cfg_stop2;
   logic               s_a;
   logic               s_b;
   logic [2:0]         bit_idx;
   logic [7:0]         shreg;
   logic               par_bit;
   logic               perr;
   logic               ferr;
   logic               push_req;
   logic [TDATA_W-1:0] push_word;

   logic [DIV_W-1:0]   half;
   logic               bit_end;
   logic               mid;
   logic               vote;
   logic               fifo_empty;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; with = the second sync stage would collapse into the first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   assign half    = cfg_div >> 1;
   assign bit_end = (cnt == cfg_div - 1'b1);
   assign mid     = (cnt == half + 1'b1);
   // Samples at h-1 and h are held in s_a/s_b; the third is the live line at h+1.
   assign vote    = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rx_idle   <= 1'b1;
         cnt       <= '0;
         cfg_div   <= '0;
         cfg_nbits <= 4'd8;
         cfg_pen   <= 1'b0;
         cfg_ptype <= 1'b0;
         cfg_stop2 <= 1'b0;
         s_a       <= 1'b1;
         s_b       <= 1'b1;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         perr      <= 1'b0;
         ferr      <= 1'b0;
         push_req  <= 1'b0;
         push_word <= '0;
      end else begin
         push_req <= 1'b0;

         // The bit counter free-runs across bit boundaries; state changes happen
         // at the mid-bit vote, so the next state's vote lands one bit later.
         if (state != ST_IDLE && state != ST_BRKWAIT) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (cnt == half - 1'b1) s_a <= rx_sync;
            if (cnt == half)        s_b <= rx_sync;
         end

         case (state)
            ST_IDLE: begin
               if (!rx_sync) begin
                  state   <= ST_START;
                  rx_idle <= 1'b0;
                  cnt     <= '0;
                  // Times the start bit; reloaded at confirmation below.
                  cfg_div <= clkdiv;
               end
            end

            ST_START: begin
               if (mid) begin
                  if (vote) begin
                     state   <= ST_IDLE;
                     rx_idle <= 1'b1;
                  end else begin
                     state     <= ST_DATA;
                     cfg_div   <= clkdiv;
                     cfg_nbits <= data_bits_count(data_bits);
                     cfg_pen   <= parity_enable;
                     cfg_ptype <= parity_type;
                     cfg_stop2 <= stop_bits;
                     bit_idx   <= '0;
                     shreg     <= '0;
                     par_bit   <= 1'b0;
                     perr      <= 1'b0;
                     ferr      <= 1'b0;
                  end
               end
            end

            ST_DATA: begin
               if (mid) begin
                  shreg[bit_idx] <= vote;
                  bit_idx        <= bit_idx + 1'b1;
                  if ({1'b0, bit_idx} == cfg_nbits - 4'd1) begin
                     state <= cfg_pen ? ST_PARITY : ST_STOP1;
                  end
               end
            end

            ST_PARITY: begin
               if (mid) begin
                  par_bit <= vote;
                  perr    <= ((^shreg) ^ vote) != cfg_ptype;
                  state   <= ST_STOP1;
               end
            end

            ST_STOP1: begin
               if (mid) begin
                  if (!vote && shreg == '0 && !(cfg_pen && par_bit)) begin
                     push_req  <= 1'b1;
                     push_word <= make_word(1'b1, 1'b0, 1'b0, 8'h00);
                     state     <= ST_BRKWAIT;
                  end else if (cfg_stop2) begin
                     ferr  <= ~vote;
                     state <= ST_STOP2;
                  end else begin
                     push_req  <= 1'b1;
                     push_word <= make_word(1'b0, ~vote, perr, shreg);
                     state     <= ST_IDLE;
                     rx_idle   <= 1'b1;
                  end
               end
            end

            ST_STOP2: begin
               if (mid) begin
                  push_req  <= 1'b1;
                  push_word <= make_word(1'b0, ferr | ~vote, perr, shreg);
                  state     <= ST_IDLE;
                  rx_idle   <= 1'b1;
               end
            end

            ST_BRKWAIT: begin
               if (rx_sync) begin
                  state   <= ST_IDLE;
                  rx_idle <= 1'b1;
               end
            end

            default: begin
               state   <= ST_IDLE;
               rx_idle <= 1'b1;
            end
         endcase
      end
   end

   assign m_axis.o_tvalid = ~fifo_empty;

   axi_uart_fifo #(
      .WIDTH (TDATA_W),
      .SIZE  (SIZE)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push_req),
      .wr_data (push_word),
      .rd_en   (m_axis.o_tready),
      .rd_data (m_axis.o_tdata),
      .empty   (fifo_empty),
      .level   (fifo_level),
      .overrun (overrun)
   );

endmodule

// File: tb/tb_axi_uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// tb_axi_uart_rx_ovs
// Self-checking bench for axi_uart_rx_ovs (SIZE=2, clkdiv=32).
// -----------------------------------------------------------------------------
module tb_axi_uart_rx_ovs;

   localparam int SIZE = 2;
   localparam int DIV  = 32;
   localparam int HALF = DIV / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  clkdiv;
   logic [1:0]   data_bits;
   logic         parity_enable;
   logic         parity_type;
   logic         stop_bits;
   logic         rx;
   logic [SIZE:0] fifo_level;
   logic         overrun;
   logic         rx_idle;

   axi_uart_rx_ovs_if u_axis ();

   axi_uart_rx_ovs #(.SIZE(SIZE), .DIV_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clkdiv        (clkdiv),
      .data_bits     (data_bits),
      .parity_enable (parity_enable),
      .parity_type   (parity_type),
      .stop_bits     (stop_bits),
      .rx            (rx),
      .m_axis        (u_axis),
      .fifo_level    (fifo_level),
      .overrun       (overrun),
      .rx_idle       (rx_idle)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ovr_cnt  = 0;
   logic [10:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && overrun) ovr_cnt++;
      if (rst_n && u_axis.o_tvalid && u_axis.o_tready) begin
         if (exp_q.size() == 0) check("spurious_char", 32'(exp_q.size()), 32'd1);
         else                   check("rx_char", 32'(u_axis.o_tdata), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bit time; optionally inverts the line for the single clk of the middle sample.
   task automatic drive_bit(input bit v, input bit glitch);
      for (int c = 0; c < DIV; c++) begin
         rx = (glitch && c == HALF + 1) ? ~v : v;
         tick();
      end
   endtask

   function automatic logic [10:0] exp_word(input logic [7:0] d, input int nb, input bit pen,
                                            input bit ptype, input bit pbit, input bit s1,
                                            input bit s2, input bit two);
      logic [7:0] m;
      logic       fe;
      logic       pe;
      m  = d & (8'hFF >> (8 - nb));
      if (m == 8'h00 && (!pen || !pbit) && !s1) return 11'h400;
      fe = !s1 || (two && !s2);
      pe = pen && (((^m) ^ pbit) != ptype);
      return {1'b0, fe, pe, m};
   endfunction

   // Sends one frame using the current configuration inputs.
   task automatic xfer(input logic [7:0] d, input bit bad_par, input bit s1, input bit s2,
                       input int gl_bit, input bit expect_push);
      int nb;
      bit pbit;
      bit q [$];
      nb   = int'(data_bits) + 5;
      pbit = (^(d & (8'hFF >> (8 - nb)))) ^ parity_type ^ bad_par;
      if (expect_push)
         exp_q.push_back(exp_word(d, nb, parity_enable, parity_type, pbit, s1, s2, stop_bits));
      q.push_back(1'b0);
      for (int i = 0; i < nb; i++) q.push_back(d[i]);
      if (parity_enable) q.push_back(pbit);
      q.push_back(s1);
      if (stop_bits) q.push_back(s2);
      foreach (q[i]) drive_bit(q[i], i == gl_bit);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int ovr0;
      logic [7:0] stream [4] = '{8'h55, 8'hA5, 8'h00, 8'hFF};

      rst_n = 1'b0;  rx = 1'b1;  u_axis.o_tready = 1'b0;
      clkdiv = 16'(DIV); data_bits = 2'b11; parity_enable = 1'b0;
      parity_type = 1'b0; stop_bits = 1'b0;
      repeat (3) tick();
      check("rst_tvalid", 32'(u_axis.o_tvalid), 32'd0);
      check("rst_level",  32'(fifo_level), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_idle",   32'(rx_idle), 32'd1);
      check("rst_tdata",  32'(u_axis.o_tdata), 32'd0);
      rst_n = 1'b1;
      repeat (4) tick();

      // 8N1 back-to-back stream, held in the FIFO, then drained.
      ovr0 = ovr_cnt;
      foreach (stream[i]) xfer(stream[i], 1'b0, 1'b1, 1'b1, -1, 1'b1);
      tick();
      check("stream_level", 32'(fifo_level), 32'd4);
      check("stream_head_hold", 32'(u_axis.o_tdata), 32'h055);
      check("stream_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
      u_axis.o_tready = 1'b1;
      wait_drain("stream_drain", 50);
      tick();
      check("stream_empty", 32'(u_axis.o_tvalid), 32'd0);

      // 5O2: correct parity, bad parity, bad second stop bit.
      data_bits = 2'b00; parity_enable = 1'b1; parity_type = 1'b1; stop_bits = 1'b1;
      xfer(8'h13, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      xfer(8'h13, 1'b1, 1'b1, 1'b1, -1, 1'b1);
      xfer(8'h13, 1'b0, 1'b1, 1'b0, -1, 1'b1);
      drive_bit(1'b1, 1'b0);
      wait_drain("parity_drain", 50);

      // Short idle glitch: start detected after 3 clk, then rejected.
      data_bits = 2'b11; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
      rx = 1'b0;
      tick(); tick();
      check("start_lat_early", 32'(rx_idle), 32'd1);
      tick();
      check("start_lat", 32'(rx_idle), 32'd0);
      repeat (5) tick();
      rx = 1'b1;
      repeat (2 * DIV) tick();
      check("false_start_idle", 32'(rx_idle), 32'd1);
      check("false_start_nopush", 32'(fifo_level), 32'd0);

      // Single-clk glitches on the middle sample of data bits.
      xfer(8'hA5, 1'b0, 1'b1, 1'b1, 4, 1'b1);
      xfer(8'h3C, 1'b0, 1'b1, 1'b1, 1, 1'b1);
      drive_bit(1'b1, 1'b0);
      wait_drain("glitch_drain", 50);

      // Break: line low for three frame times.
      u_axis.o_tready = 1'b0;
      exp_q.push_back(11'h400);
      for (int i = 0; i < 30; i++) drive_bit(1'b0, 1'b0);
      check("break_level", 32'(fifo_level), 32'd1);
      check("break_wait", 32'(rx_idle), 32'd0);
      rx = 1'b1;
      repeat (4) tick();
      check("break_release", 32'(rx_idle), 32'd1);
      u_axis.o_tready = 1'b1;
      drive_bit(1'b1, 1'b0);
      xfer(8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      drive_bit(1'b1, 1'b0);
      wait_drain("break_drain", 50);

      // Overrun on a full FIFO, then push and pop in the same cycle.
      u_axis.o_tready = 1'b0;
      ovr0 = ovr_cnt;
      for (int i = 0; i < 5; i++) xfer(8'(8'h10 + i), 1'b0, 1'b1, 1'b1, -1, i < 4);
      tick();
      check("ovr_level", 32'(fifo_level), 32'd4);
      check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
      fork
         xfer(8'h66, 1'b0, 1'b1, 1'b1, -1, 1'b1);
         begin
            repeat (9 * DIV + HALF + 5) tick();
            u_axis.o_tready = 1'b1;
            tick();
            u_axis.o_tready = 1'b0;
         end
      join
      tick();
      check("ovr_pushpop_level", 32'(fifo_level), 32'd4);
      check("ovr_pushpop_pulses", 32'(ovr_cnt - ovr0), 32'd1);
      check("ovr_head", 32'(u_axis.o_tdata), 32'h011);
      u_axis.o_tready = 1'b1;
      wait_drain("ovr_drain", 50);

      // Reset in the middle of DATA with a character buffered.
      u_axis.o_tready = 1'b0;
      xfer(8'h5A, 1'b0, 1'b1, 1'b1, -1, 1'b0);
      tick();
      check("pre_rst_level", 32'(fifo_level), 32'd1);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
      rx = 1'b1;
      rst_n = 1'b0;
      tick();
      check("mid_rst_tvalid", 32'(u_axis.o_tvalid), 32'd0);
      check("mid_rst_level",  32'(fifo_level), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      check("mid_rst_idle",   32'(rx_idle), 32'd1);
      check("mid_rst_tdata",  32'(u_axis.o_tdata), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      u_axis.o_tready = 1'b1;
      xfer(8'h96, 1'b0, 1'b1, 1'b1, -1, 1'b1);
      drive_bit(1'b1, 1'b0);
      wait_drain("post_rst_drain", 50);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
